// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal stage fed by the intersection traffic-light controller.
// One WALK / flashing DONT_WALK / DONT_WALK sequencer per crossing, each
// slaved to the green phase of the parallel vehicle direction. Index 0 is
// the NS crossing, index 1 the EW crossing. All outputs are registered.
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 30,
  parameter int FLASH_CYCLES = 16,
  parameter int BLINK_HALF   = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       NS_light,
  input  logic [2:0]       EW_light,
  input  logic             ped_btn_ns,
  input  logic             ped_btn_ew,
  output logic             ns_walk,
  output logic             ns_dont_walk,
  output logic             ns_req_pending,
  output logic [CNT_W-1:0] ns_countdown,
  output logic             ew_walk,
  output logic             ew_dont_walk,
  output logic             ew_req_pending,
  output logic [CNT_W-1:0] ew_countdown,
  output logic             light_err
);

  localparam logic [1:0] ST_DONT_WALK = 2'd0;
  localparam logic [1:0] ST_WALK      = 2'd1;
  localparam logic [1:0] ST_FLASH     = 2'd2;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);

  function automatic logic light_illegal(input logic [2:0] l);
    return !((l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN));
  endfunction

  // Registered state (per direction where indexed)
  logic [1:0]       btn_meta_q, btn_meta_d;
  logic [1:0]       btn_sync_q, btn_sync_d;
  logic [1:0]       btn_dly_q,  btn_dly_d;
  logic             light_err_q, light_err_d;
  logic [2:0]       prev_light_q [2];
  logic [2:0]       prev_light_d [2];
  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [BLK_W-1:0] blink_cnt_q [2];
  logic [BLK_W-1:0] blink_cnt_d [2];
  logic [1:0]       blink_on_q, blink_on_d;
  logic [1:0]       req_q, req_d;
  logic [1:0]       walk_q, walk_d;
  logic [1:0]       dont_walk_q, dont_walk_d;
  logic [CNT_W-1:0] countdown_q [2];
  logic [CNT_W-1:0] countdown_d [2];

  // Combinational helpers
  logic [2:0] light [2];
  logic [1:0] btn_raw;
  logic [1:0] rise;
  logic [1:0] green;
  logic [1:0] green_start;
  logic       err_now;

  assign light[0] = NS_light;
  assign light[1] = EW_light;
  assign btn_raw  = {ped_btn_ew, ped_btn_ns};

  // Next-state logic: error check, button edge detect, per-crossing sequencer
  always_comb begin
    // An illegal code or a green/green overlap forces both crossings to red.
    err_now     = light_illegal(NS_light) || light_illegal(EW_light) ||
                  ((NS_light == LIGHT_GRN) && (EW_light == LIGHT_GRN));
    light_err_d = light_err_q | err_now;

    btn_meta_d  = btn_raw;
    btn_sync_d  = btn_meta_q;
    btn_dly_d   = btn_sync_q;
    rise        = btn_sync_q & ~btn_dly_q;

    green       = '0;
    green_start = '0;
    blink_on_d  = blink_on_q;
    req_d       = req_q;
    walk_d      = '0;
    dont_walk_d = '0;

    for (int i = 0; i < 2; i++) begin
      prev_light_d[i] = light[i];
      state_d[i]      = state_q[i];
      cnt_d[i]        = cnt_q[i];
      blink_cnt_d[i]  = blink_cnt_q[i];
      countdown_d[i]  = '0;

      green[i]       = (light[i] == LIGHT_GRN) && !err_now;
      green_start[i] = green[i] && (prev_light_q[i] != LIGHT_GRN);

      // Requests accumulate in every state; only the WALK launch clears them.
      req_d[i] = req_q[i] | rise[i];

      case (state_q[i])
        ST_DONT_WALK: begin
          // A rise coinciding with the green start is consumed by this launch.
          if (green_start[i] && (req_q[i] || rise[i])) begin
            state_d[i] = ST_WALK;
            cnt_d[i]   = WALK_LOAD;
            req_d[i]   = 1'b0;
          end
        end
        ST_WALK: begin
          if (err_now) begin
            state_d[i] = ST_DONT_WALK;
          end else if (!green[i] || (cnt_q[i] == '0)) begin
            // Walk time expired, or the vehicle phase ended early.
            state_d[i]     = ST_FLASH;
            cnt_d[i]       = FLASH_LOAD;
            blink_cnt_d[i] = '0;
            blink_on_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_FLASH: begin
          // Red (or illegal) cuts the clearance short; green starts are ignored.
          if (err_now || (light[i] == LIGHT_RED) || (cnt_q[i] == '0)) begin
            state_d[i] = ST_DONT_WALK;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (blink_cnt_q[i] == BLINK_LAST) begin
              blink_cnt_d[i] = '0;
              blink_on_d[i]  = ~blink_on_q[i];
            end else begin
              blink_cnt_d[i] = blink_cnt_q[i] + BLK_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_DONT_WALK;
        end
      endcase

      // Lamps are decoded from the next state so they land with the transition.
      walk_d[i]      = (state_d[i] == ST_WALK);
      dont_walk_d[i] = (state_d[i] == ST_DONT_WALK) ||
                       ((state_d[i] == ST_FLASH) && blink_on_d[i]);
      if (state_d[i] == ST_FLASH) begin
        countdown_d[i] = cnt_d[i] + CNT_W'(1);
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
      btn_dly_q   <= '0;
      light_err_q <= 1'b0;
      blink_on_q  <= '1;
      req_q       <= '0;
      walk_q      <= '0;
      dont_walk_q <= '1;
      for (int i = 0; i < 2; i++) begin
        prev_light_q[i] <= LIGHT_RED;
        state_q[i]      <= ST_DONT_WALK;
        cnt_q[i]        <= '0;
        blink_cnt_q[i]  <= '0;
        countdown_q[i]  <= '0;
      end
    end else begin
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
      btn_dly_q   <= btn_dly_d;
      light_err_q <= light_err_d;
      blink_on_q  <= blink_on_d;
      req_q       <= req_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      for (int i = 0; i < 2; i++) begin
        prev_light_q[i] <= prev_light_d[i];
        state_q[i]      <= state_d[i];
        cnt_q[i]        <= cnt_d[i];
        blink_cnt_q[i]  <= blink_cnt_d[i];
        countdown_q[i]  <= countdown_d[i];
      end
    end
  end

  assign ns_walk        = walk_q[0];
  assign ns_dont_walk   = dont_walk_q[0];
  assign ns_req_pending = req_q[0];
  assign ns_countdown   = countdown_q[0];
  assign ew_walk        = walk_q[1];
  assign ew_dont_walk   = dont_walk_q[1];
  assign ew_req_pending = req_q[1];
  assign ew_countdown   = countdown_q[1];
  assign light_err      = light_err_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: directed scenarios with literal expectations
// plus controller-like randomized traffic, all compared every cycle against
// a behavioural model of the pedestrian crossing rules.
module tb_ped_signal_ctrl;

  localparam int WALK  = 30;
  localparam int FLASH = 16;
  localparam int BLINK = 2;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    NS_light = 3'b100;
  logic [2:0]    EW_light = 3'b100;
  logic          ped_btn_ns = 1'b0;
  logic          ped_btn_ew = 1'b0;
  logic          ns_walk, ns_dont_walk, ns_req_pending;
  logic [CW-1:0] ns_countdown;
  logic          ew_walk, ew_dont_walk, ew_req_pending;
  logic [CW-1:0] ew_countdown;
  logic          light_err;

  int n_vec = 0;
  int n_bad = 0;

  ped_signal_ctrl #(
    .WALK_CYCLES(WALK), .FLASH_CYCLES(FLASH), .BLINK_HALF(BLINK), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .NS_light(NS_light), .EW_light(EW_light),
    .ped_btn_ns(ped_btn_ns), .ped_btn_ew(ped_btn_ew),
    .ns_walk(ns_walk), .ns_dont_walk(ns_dont_walk),
    .ns_req_pending(ns_req_pending), .ns_countdown(ns_countdown),
    .ew_walk(ew_walk), .ew_dont_walk(ew_dont_walk),
    .ew_req_pending(ew_req_pending), .ew_countdown(ew_countdown),
    .light_err(light_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 = people must wait, 1 = people walking, 2 = clearance flashing
  int         m_mode [2];
  int         m_walked [2];   // cycles of walking shown so far (1-based)
  int         m_fidx [2];     // cycles of clearance elapsed (0-based)
  bit         m_pend [2];
  bit         m_err;
  logic [2:0] m_prev [2];
  bit         m_past1 [2];    // button as sampled one, two, three edges ago
  bit         m_past2 [2];
  bit         m_past3 [2];
  logic [2:0] m_l [2];
  bit         m_bad, m_rise, m_grn, m_gstart;
  bit         m_btn [2];

  function automatic bit legal(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_err = 0;
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_walked[d] = 0; m_fidx[d] = 0; m_pend[d] = 0;
        m_prev[d] = 3'b100;
        m_past1[d] = 0; m_past2[d] = 0; m_past3[d] = 0;
      end
    end else begin
      m_l[0] = NS_light; m_l[1] = EW_light;
      m_btn[0] = ped_btn_ns; m_btn[1] = ped_btn_ew;
      m_bad = !legal(NS_light) || !legal(EW_light) ||
              (NS_light == 3'b001 && EW_light == 3'b001);
      for (int d = 0; d < 2; d++) begin
        m_rise   = m_past2[d] && !m_past3[d];
        m_grn    = (m_l[d] == 3'b001) && !m_bad;
        m_gstart = m_grn && (m_prev[d] != 3'b001);
        if (m_mode[d] == 0) begin
          if (m_gstart && (m_pend[d] || m_rise)) begin
            m_mode[d] = 1; m_walked[d] = 1; m_pend[d] = 0;
          end else if (m_rise) m_pend[d] = 1;
        end else if (m_mode[d] == 1) begin
          if (m_rise) m_pend[d] = 1;
          if (m_bad) m_mode[d] = 0;
          else if (!m_grn || m_walked[d] == WALK) begin
            m_mode[d] = 2; m_fidx[d] = 0;
          end else m_walked[d]++;
        end else begin
          if (m_rise) m_pend[d] = 1;
          if (m_bad || m_l[d] == 3'b100 || m_fidx[d] == FLASH - 1) m_mode[d] = 0;
          else m_fidx[d]++;
        end
        m_prev[d]  = m_l[d];
        m_past3[d] = m_past2[d];
        m_past2[d] = m_past1[d];
        m_past1[d] = m_btn[d];
      end
      if (m_bad) m_err = 1;
    end
  end

  function automatic int exp_walk(input int d);
    return (m_mode[d] == 1) ? 1 : 0;
  endfunction
  function automatic int exp_dw(input int d);
    if (m_mode[d] == 0) return 1;
    if (m_mode[d] == 2) return ((m_fidx[d] / BLINK) % 2 == 0) ? 1 : 0;
    return 0;
  endfunction
  function automatic int exp_cd(input int d);
    return (m_mode[d] == 2) ? (FLASH - m_fidx[d]) : 0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ns_walk",    ns_walk,        exp_walk(0));
    chk("ns_dw",      ns_dont_walk,   exp_dw(0));
    chk("ns_pending", ns_req_pending, int'(m_pend[0]));
    chk("ns_cd",      ns_countdown,   exp_cd(0));
    chk("ew_walk",    ew_walk,        exp_walk(1));
    chk("ew_dw",      ew_dont_walk,   exp_dw(1));
    chk("ew_pending", ew_req_pending, int'(m_pend[1]));
    chk("ew_cd",      ew_countdown,   exp_cd(1));
    chk("light_err",  light_err,      int'(m_err));
    chk("ns_excl",    int'(ns_walk & ns_dont_walk), 0);
    chk("ew_excl",    int'(ew_walk & ew_dont_walk), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    NS_light = 3'b100; EW_light = 3'b100;
    ped_btn_ns = 1'b0; ped_btn_ew = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rtick();
    tick();
    if ($urandom_range(0, 24) == 0) ped_btn_ns = ~ped_btn_ns;
    if ($urandom_range(0, 24) == 0) ped_btn_ew = ~ped_btn_ew;
  endtask

  task automatic run_period();
    int g, y, r;
    for (int d = 0; d < 2; d++) begin
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 45);
      y = $urandom_range(1, 5);
      r = $urandom_range(0, 3);
      if (d == 0) begin NS_light = 3'b001; EW_light = 3'b100; end
      else        begin NS_light = 3'b100; EW_light = 3'b001; end
      repeat (g) rtick();
      if (d == 0) NS_light = 3'b010; else EW_light = 3'b010;
      repeat (y) rtick();
      NS_light = 3'b100; EW_light = 3'b100;
      repeat (r) rtick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_ns_walk", ns_walk, 0);
    chk("rst_ns_dw",   ns_dont_walk, 1);
    chk("rst_ew_dw",   ew_dont_walk, 1);
    chk("rst_err",     light_err, 0);
    @(negedge clk);
    reset = 1'b0;

    // NS request made during EW green, then served by NS green.
    EW_light = 3'b001;
    repeat (2) tick();
    ped_btn_ns = 1'b1;
    tick();
    tick();
    chk("ns_pend_early", ns_req_pending, 0);
    tick();
    chk("ns_pend_set", ns_req_pending, 1);
    ped_btn_ns = 1'b0;
    repeat (2) tick();
    EW_light = 3'b100; NS_light = 3'b001;
    tick();
    chk("walk_start", ns_walk, 1);
    chk("req_cleared", ns_req_pending, 0);
    repeat (WALK - 1) tick();
    chk("walk_last", ns_walk, 1);
    tick();
    chk("flash_walk", ns_walk, 0);
    chk("flash_cd16", ns_countdown, 16);
    chk("blink0", ns_dont_walk, 1);
    tick(); chk("blink1", ns_dont_walk, 1); chk("flash_cd15", ns_countdown, 15);
    tick(); chk("blink2", ns_dont_walk, 0);
    tick(); chk("blink3", ns_dont_walk, 0);
    repeat (12) tick();
    chk("flash_cd1", ns_countdown, 1);
    tick();
    chk("flash_end_cd", ns_countdown, 0);
    chk("flash_end_dw", ns_dont_walk, 1);
    repeat (10) tick();

    // Early abort: green cut to 10 cycles, red after 5 yellow.
    NS_light = 3'b010; repeat (3) tick();
    NS_light = 3'b100; EW_light = 3'b001; repeat (4) tick();
    EW_light = 3'b100;
    ped_btn_ns = 1'b1; tick(); ped_btn_ns = 1'b0;
    repeat (3) tick();
    chk("abort_pend", ns_req_pending, 1);
    NS_light = 3'b001;
    tick(); chk("abort_walk", ns_walk, 1);
    repeat (9) tick();
    NS_light = 3'b010;
    tick();
    chk("abort_flash_walk", ns_walk, 0);
    chk("abort_flash_cd", ns_countdown, 16);
    repeat (4) tick();
    NS_light = 3'b100;
    tick();
    chk("abort_red_cd", ns_countdown, 0);
    chk("abort_red_dw", ns_dont_walk, 1);

    // Controller-like randomized traffic with random button activity.
    repeat (25) run_period();
    ped_btn_ns = 1'b0; ped_btn_ew = 1'b0;
    NS_light = 3'b100; EW_light = 3'b100;
    repeat (5) tick();

    // Illegal code mid-WALK.
    apply_reset();
    ped_btn_ns = 1'b1; tick(); ped_btn_ns = 1'b0;
    repeat (3) tick();
    NS_light = 3'b001; tick();
    repeat (4) tick();
    chk("ill_pre_walk", ns_walk, 1);
    NS_light = 3'b011; tick();
    chk("ill_err", light_err, 1);
    chk("ill_walk", ns_walk, 0);
    chk("ill_dw", ns_dont_walk, 1);
    NS_light = 3'b001; tick();
    NS_light = 3'b100; repeat (3) tick();
    chk("ill_sticky", light_err, 1);

    // Green overlap during EW WALK.
    apply_reset();
    ped_btn_ew = 1'b1; tick(); ped_btn_ew = 1'b0;
    repeat (3) tick();
    EW_light = 3'b001; tick();
    chk("ovl_ew_walk_pre", ew_walk, 1);
    repeat (3) tick();
    NS_light = 3'b001; tick();
    chk("ovl_err", light_err, 1);
    chk("ovl_ew_walk", ew_walk, 0);
    chk("ovl_ew_dw", ew_dont_walk, 1);
    NS_light = 3'b100; repeat (3) tick();

    // Asynchronous reset in the middle of FLASH.
    apply_reset();
    ped_btn_ns = 1'b1; tick(); ped_btn_ns = 1'b0;
    repeat (3) tick();
    NS_light = 3'b001;
    repeat (WALK + 3) tick();
    chk("pre_rst_cd", ns_countdown, 14);
    #2 reset = 1'b1;
    #1;
    chk("arst_walk", ns_walk, 0);
    chk("arst_dw", ns_dont_walk, 1);
    chk("arst_cd", ns_countdown, 0);
    chk("arst_pend", ns_req_pending, 0);
    chk("arst_err", light_err, 0);
    check_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) tick();
    chk("post_rst_no_walk", ns_walk, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Pedestrian signal stage sitting directly downstream of the intersection traffic-light controller.
- Consumes the controller's one-hot NS_light/EW_light vehicle lamp codes and two pedestrian push-buttons.
- Drives WALK / flashing DONT_WALK / DONT_WALK lamps and a flash countdown for each crossing.
- Pedestrians crossing parallel to NS traffic (ns_*) may walk only during NS green; likewise ew_* during EW green.

Parameters:
WALK_CYCLES, 30, cycles of steady WALK (>=1)
FLASH_CYCLES, 16, cycles of flashing DONT_WALK (>=1, < 2**CNT_W)
BLINK_HALF, 2, half-period in cycles of the flash blink (>=1)
CNT_W, 8, width of phase counters and countdown outputs

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
NS_light  input  3  NS vehicle lamp, one-hot: red=100, yellow=010, green=001
EW_light  input  3  EW vehicle lamp, same encoding
ped_btn_ns  input  1  NS-crossing button, asynchronous level
ped_btn_ew  input  1  EW-crossing button, asynchronous level
ns_walk  output  1  NS WALK lamp
ns_dont_walk  output  1  NS DONT_WALK lamp (blinks during flash)
ns_req_pending  output  1  NS request acknowledged, not yet served
ns_countdown  output  CNT_W  NS flash cycles remaining, 0 outside flash
ew_walk, ew_dont_walk, ew_req_pending, ew_countdown  output  1/1/1/CNT_W  EW equivalents
light_err  output  1  sticky illegal-input flag

Behaviour:
- Reset: all outputs registered. walk=0, dont_walk=1, req_pending=0, countdown=0, light_err=0, FSMs=DONT_WALK, prev-light registers=100 (red), synchronisers=0.
- Buttons: 2-FF synchroniser + 1 delay FF per button; rise = sync & ~sync_d. req_pending sets on the edge after rise, i.e. 2 cycles after the edge that first samples the button high. Held buttons generate one request only.
- Light decode per direction: green = (light==001) and no error; green_start = green && prev_light!=001; prev_light is registered every cycle.
- Illegal input: any light code outside {100,010,001}, or both lights 001 at once. Sets light_err (sticky until reset). That cycle both directions are treated as red: any WALK/FLASH moves to DONT_WALK at that edge. Requests are kept.
- Per-direction FSM: DONT_WALK, WALK, FLASH.
- DONT_WALK -> WALK: at an edge with green_start && (req_pending || rise). Load cnt=WALK_CYCLES-1 and clear req_pending. A rise in the same cycle is consumed. A request without green_start (mid-green, yellow, red) waits for the next green_start.
- WALK: cnt decrements each cycle.
  - cnt==0 && green -> FLASH.
  - Light leaves green early (yellow/red) -> FLASH immediately.
  - Both cases load cnt=FLASH_CYCLES-1 and reset the blink counter.
- FLASH: cnt decrements.
  - cnt==0 -> DONT_WALK.
  - Light red or illegal -> DONT_WALK immediately, taking priority over cnt.
  - green_start while in FLASH is ignored; the request stays pending.
- Requests arriving in WALK/FLASH set req_pending and are served at the next green_start.
- Outputs:
  - walk=1 only in WALK.
  - dont_walk=1 in DONT_WALK. In FLASH it is 1 for BLINK_HALF cycles, 0 for BLINK_HALF cycles, repeating, starting at 1.
  - countdown=cnt+1 in FLASH, else 0.
  - walk and dont_walk are never both 1.
- Latency: lamp outputs change on the edge after the triggering input condition (1 cycle).
- The two directions are fully independent apart from the shared error check.

Test Plan:
- NS request served: pulse ped_btn_ns for 3 cycles during EW green; ns_req_pending=1 two cycles later. Drive NS_light=001 for 60 cycles. Expect 1 cycle later: ns_walk=1 for 30 cycles, req cleared. Then FLASH for 16 cycles with ns_countdown 16..1 and ns_dont_walk pattern 1,1,0,0 repeating. Then ns_dont_walk steady 1, countdown 0.
- Early abort: request pending, NS green for 10 cycles then 010. WALK ends after 10 cycles and FLASH starts with countdown 16. NS_light=100 after 5 yellow cycles -> DONT_WALK on the next edge, countdown 0.
- No request: 3 full controller periods without button presses -> walk never 1, dont_walk constant 1, req_pending 0.
- Late request: press ped_btn_ew in the 5th cycle of WALK and in mid-green with no walk active. Each press stays pending (ew_req_pending=1) and is served only at the next EW green_start.
- Illegal/overlap: drive NS_light=011 mid-WALK -> light_err=1, ns_walk=0, ns_dont_walk=1 on the next edge. light_err stays 1 after legal codes return. Both lights=001 -> same response.
- Reset mid-FLASH: assert reset asynchronously -> outputs immediately walk=0, dont_walk=1, countdown=0, req_pending=0, light_err=0. After release with NS green held, no walk starts without a new request.
